// File: rtl/execute_alu_result_stage.sv
// execute_alu_result_stage: ALU result register with CR0 derivation and pending/committed XER SO/OV/CA tracking
module execute_alu_result_stage #(
  parameter int REGSZ = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REGSZ-1:0] in_res,
  input  logic             in_co,
  input  logic             in_ov,
  input  logic             in_set_ca,
  input  logic             in_set_ov,
  input  logic             in_set_cr0,
  input  logic             in_wr_xer,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REGSZ-1:0] out_res,
  output logic [3:0]       out_cr0,
  output logic             out_set_cr0,
  output logic             xer_so,
  output logic             xer_ov,
  output logic             xer_ca,
  output logic             fwd_ca
);
  logic p_so, p_ov, p_ca, f_ov, f_ca, acc, con;
  logic e_so, e_ov, e_ca, n_so, n_ov, n_ca, lt, eq;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready && !flush;
  assign con = out_valid && out_ready && !flush;
  assign fwd_ca = (out_valid && f_ca) ? p_ca : xer_ca;
  always_comb begin
    e_so = (out_valid && !con) ? p_so : (con && f_ov) ? p_so : xer_so;
    e_ov = (out_valid && !con) ? p_ov : (con && f_ov) ? p_ov : xer_ov;
    e_ca = (out_valid && !con) ? p_ca : (con && f_ca) ? p_ca : xer_ca;
    n_so = in_wr_xer ? in_res[31] : e_so | (in_set_ov & in_ov);
    n_ov = in_wr_xer ? in_res[30] : in_set_ov ? in_ov : e_ov;
    n_ca = in_wr_xer ? in_res[29] : in_set_ca ? in_co : e_ca;
    lt = in_res[REGSZ-1];
    eq = in_res == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_res <= '0;
      out_cr0 <= '0;
      out_set_cr0 <= 1'b0;
      {p_so, p_ov, p_ca, f_ov, f_ca} <= '0;
      {xer_so, xer_ov, xer_ca} <= '0;
    end else begin
      if (con && f_ov) {xer_so, xer_ov} <= {p_so, p_ov};
      if (con && f_ca) xer_ca <= p_ca;
      if (flush) out_valid <= 1'b0;
      else if (acc) out_valid <= 1'b1;
      else if (con) out_valid <= 1'b0;
      if (acc) begin
        out_res <= in_res;
        out_set_cr0 <= in_set_cr0;
        out_cr0 <= {lt, !lt && !eq, eq, n_so};
        {p_so, p_ov, p_ca} <= {n_so, n_ov, n_ca};
        f_ov <= in_wr_xer || in_set_ov;
        f_ca <= in_wr_xer || in_set_ca;
      end
    end
  end
endmodule

// File: tb/tb_execute_alu_result_stage.sv
// tb_execute_alu_result_stage: directed self-checking bench for execute_alu_result_stage
module tb_execute_alu_result_stage;
  logic clk = 1'b0, reset, in_valid, in_ready, in_co, in_ov, in_set_ca, in_set_ov, in_set_cr0, in_wr_xer;
  logic flush, out_valid, out_ready, out_set_cr0, xer_so, xer_ov, xer_ca, fwd_ca;
  logic [31:0] in_res, out_res;
  logic [3:0] out_cr0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  execute_alu_result_stage #(.REGSZ(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
    .in_co(in_co), .in_ov(in_ov), .in_set_ca(in_set_ca), .in_set_ov(in_set_ov),
    .in_set_cr0(in_set_cr0), .in_wr_xer(in_wr_xer), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_cr0(out_cr0), .out_set_cr0(out_set_cr0),
    .xer_so(xer_so), .xer_ov(xer_ov), .xer_ca(xer_ca), .fwd_ca(fwd_ca)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] res, input logic co, input logic ov,
                       input logic sca, input logic sov, input logic scr, input logic wx);
    in_valid = 1'b1;
    in_res = res;
    {in_co, in_ov, in_set_ca, in_set_ov, in_set_cr0, in_wr_xer} = {co, ov, sca, sov, scr, wx};
  endtask
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    in_res = '0;
    {in_co, in_ov, in_set_ca, in_set_ov, in_set_cr0, in_wr_xer} = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", out_res, 0);
    chk("rst_cr0", out_cr0, 0);
    chk("rst_xer", {xer_so, xer_ov, xer_ca}, 0);
    chk("rst_fwd_ca", fwd_ca, 0);
    drive(32'h8000_0000, 0, 0, 0, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_cr0", out_cr0, 4'b1000);
    chk("t1_set_cr0", out_set_cr0, 1);
    tick();
    chk("t1_drained", out_valid, 0);
    out_ready = 1'b0;
    drive(32'h5, 1, 0, 1, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("t2_fwd_ca", fwd_ca, 1);
    chk("t2_xer_ca_held", xer_ca, 0);
    tick();
    chk("t2_xer_ca_stall", xer_ca, 0);
    chk("t2_fwd_ca_stall", fwd_ca, 1);
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready", in_ready, 1);
    tick();
    chk("t2_xer_ca", xer_ca, 1);
    chk("t2_drained", out_valid, 0);
    drive(32'h7, 0, 1, 0, 1, 0, 0);
    tick();
    drive(32'h3, 0, 0, 0, 1, 1, 0);
    tick();
    in_valid = 1'b0;
    chk("t3_first_commit", {xer_so, xer_ov}, 2'b11);
    chk("t3_cr0", out_cr0, 4'b0101);
    chk("t3_res", out_res, 32'h3);
    tick();
    chk("t3_xer_so_ov", {xer_so, xer_ov}, 2'b10);
    chk("t3_xer_ca_kept", xer_ca, 1);
    drive(32'hA000_0000, 0, 0, 0, 0, 0, 1);
    tick();
    drive(32'h0, 0, 0, 0, 0, 1, 0);
    tick();
    in_valid = 1'b0;
    chk("t4_xer", {xer_so, xer_ov, xer_ca}, 3'b101);
    chk("t4_cr0", out_cr0, 4'b0011);
    tick();
    drive(32'h0, 0, 0, 0, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t4_xer_clear", {xer_so, xer_ov, xer_ca}, 3'b000);
    out_ready = 1'b0;
    drive(32'h1, 1, 0, 1, 0, 0, 0);
    tick();
    chk("t5_fwd_ca_held", fwd_ca, 1);
    drive(32'h9, 1, 0, 1, 0, 0, 0);
    flush = 1'b1;
    #1;
    chk("t5_in_ready_flush", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_xer_ca", xer_ca, 0);
    chk("t5_fwd_ca", fwd_ca, 0);
    out_ready = 1'b1;
    tick();
    chk("t5_dropped", out_valid, 0);
    out_ready = 1'b0;
    drive(32'h11, 0, 0, 0, 0, 0, 0);
    tick();
    drive(32'h22, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_in_ready", in_ready, 0);
      chk("t6_res_stable", out_res, 32'h11);
      tick();
    end
    chk("t6_still_held", out_res, 32'h11);
    out_ready = 1'b1;
    #1;
    chk("t6_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t6_next_res", out_res, 32'h22);
    chk("t6_next_valid", out_valid, 1);
    tick();
    chk("t6_drained", out_valid, 0);
    chk("t6_xer_untouched", {xer_so, xer_ov, xer_ca}, 3'b000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
